decode_stage: RTL and testbench

Instruction-decode stage of the pipelined RV64I core. Accepts the IF/ID instruction, drives the register file read addresses, and generates immediates and control. It detects load-use hazards and registers everything into the ID/EX pipeline register consumed by the execute stage. The register file sits directly beside this block: `rf_rs1`/`rf_rs2` feed its read ports and `rf_read_data1`/`rf_read_data2` return combinationally.

---
 rtl/decode_stage.sv | 174 +++++++++++++++++
 tb/tb_decode_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV64I instruction-decode stage: opcode/immediate decode, load-use hazard
// detection and the ID/EX pipeline register feeding the execute stage.
module decode_stage #(
   parameter int unsigned XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            if_valid,
   input  logic [XLEN-1:0] if_pc,
   input  logic [31:0]     if_instr,
   input  logic            flush,
   output logic [4:0]      rf_rs1,
   output logic [4:0]      rf_rs2,
   input  logic [XLEN-1:0] rf_read_data1,
   input  logic [XLEN-1:0] rf_read_data2,
   output logic            stall,
   output logic            ex_valid,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_rs1_data,
   output logic [XLEN-1:0] ex_rs2_data,
   output logic [XLEN-1:0] ex_imm,
   output logic [4:0]      ex_rs1,
   output logic [4:0]      ex_rs2,
   output logic [4:0]      ex_rd,
   output logic [2:0]      ex_funct3,
   output logic            ex_funct7_5,
   output logic [1:0]      ex_alu_op,
   output logic            ex_alu_src,
   output logic            ex_reg_write,
   output logic            ex_mem_read,
   output logic            ex_mem_write,
   output logic            ex_mem_to_reg,
   output logic            ex_branch,
   output logic            ex_illegal
);

   typedef enum logic [6:0] {
      OP_R      = 7'b0110011,
      OP_IMM    = 7'b0010011,
      OP_LOAD   = 7'b0000011,
      OP_STORE  = 7'b0100011,
      OP_BRANCH = 7'b1100011
   } opcode_e;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [2:0]      funct3;
      logic            funct7_5;
      logic [1:0]      alu_op;
      logic            alu_src;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
      logic            mem_to_reg;
      logic            branch;
      logic            illegal;
   } idex_t;

   opcode_e         opcode;
   idex_t           dec;
   idex_t           idex_d;
   idex_t           idex_q;
   logic            use_rs1;
   logic            use_rs2;
   logic            hit_rs1;
   logic            hit_rs2;
   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_s;
   logic [XLEN-1:0] imm_b;

   assign opcode = opcode_e'(if_instr[6:0]);
   assign rf_rs1 = if_instr[19:15];
   assign rf_rs2 = if_instr[24:20];

   assign imm_i = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
   assign imm_s = {{(XLEN-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
   assign imm_b = {{(XLEN-13){if_instr[31]}}, if_instr[31], if_instr[7],
                   if_instr[30:25], if_instr[11:8], 1'b0};

   always_comb begin
      dec          = '0;
      use_rs1      = 1'b0;
      use_rs2      = 1'b0;
      dec.valid    = 1'b1;
      dec.pc       = if_pc;
      dec.rs1_data = rf_read_data1;
      dec.rs2_data = rf_read_data2;
      dec.rs1      = if_instr[19:15];
      dec.rs2      = if_instr[24:20];
      dec.rd       = if_instr[11:7];
      dec.funct3   = if_instr[14:12];
      dec.funct7_5 = if_instr[30];
      case (opcode)
         OP_R: begin
            dec.reg_write = 1'b1;
            dec.alu_op    = 2'b10;
            use_rs1       = 1'b1;
            use_rs2       = 1'b1;
         end
         OP_IMM: begin
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.alu_op    = 2'b11;
            dec.imm       = imm_i;
            use_rs1       = 1'b1;
         end
         OP_LOAD: begin
            dec.reg_write  = 1'b1;
            dec.mem_read   = 1'b1;
            dec.mem_to_reg = 1'b1;
            dec.alu_src    = 1'b1;
            dec.alu_op     = 2'b00;
            dec.imm        = imm_i;
            use_rs1        = 1'b1;
         end
         OP_STORE: begin
            dec.mem_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.alu_op    = 2'b00;
            dec.imm       = imm_s;
            use_rs1       = 1'b1;
            use_rs2       = 1'b1;
         end
         OP_BRANCH: begin
            dec.branch = 1'b1;
            dec.alu_op = 2'b01;
            dec.imm    = imm_b;
            use_rs1    = 1'b1;
            use_rs2    = 1'b1;
         end
         default: dec.illegal = 1'b1;
      endcase
   end

   // A load into x0 never produces a value worth waiting for.
   assign hit_rs1 = use_rs1 & (idex_q.rd == dec.rs1);
   assign hit_rs2 = use_rs2 & (idex_q.rd == dec.rs2);
   assign stall   = if_valid & idex_q.valid & idex_q.mem_read &
                    (idex_q.rd != 5'd0) & (hit_rs1 | hit_rs2) & ~flush;

   assign idex_d = (flush | stall | ~if_valid) ? idex_t'('0) : dec;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) idex_q <= '0;
      else       idex_q <= idex_d;
   end

   assign ex_valid      = idex_q.valid;
   assign ex_pc         = idex_q.pc;
   assign ex_rs1_data   = idex_q.rs1_data;
   assign ex_rs2_data   = idex_q.rs2_data;
   assign ex_imm        = idex_q.imm;
   assign ex_rs1        = idex_q.rs1;
   assign ex_rs2        = idex_q.rs2;
   assign ex_rd         = idex_q.rd;
   assign ex_funct3     = idex_q.funct3;
   assign ex_funct7_5   = idex_q.funct7_5;
   assign ex_alu_op     = idex_q.alu_op;
   assign ex_alu_src    = idex_q.alu_src;
   assign ex_reg_write  = idex_q.reg_write;
   assign ex_mem_read   = idex_q.mem_read;
   assign ex_mem_write  = idex_q.mem_write;
   assign ex_mem_to_reg = idex_q.mem_to_reg;
   assign ex_branch     = idex_q.branch;
   assign ex_illegal    = idex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode, immediates, load-use stall,
// flush priority and asynchronous reset.
module tb_decode_stage;

   localparam int unsigned XLEN = 64;

   logic            clk = 1'b0;
   logic            reset;
   logic            if_valid;
   logic [XLEN-1:0] if_pc;
   logic [31:0]     if_instr;
   logic            flush;
   logic [4:0]      rf_rs1, rf_rs2;
   logic [XLEN-1:0] rf_read_data1, rf_read_data2;
   logic            stall;
   logic            ex_valid;
   logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [4:0]      ex_rs1, ex_rs2, ex_rd;
   logic [2:0]      ex_funct3;
   logic            ex_funct7_5;
   logic [1:0]      ex_alu_op;
   logic            ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write;
   logic            ex_mem_to_reg, ex_branch, ex_illegal;

   logic [XLEN-1:0] rf [32];
   int              checks = 0;
   int              errors = 0;

   assign rf_read_data1 = rf[rf_rs1];
   assign rf_read_data2 = rf[rf_rs2];

   always #5 clk = ~clk;

   decode_stage #(.XLEN(XLEN)) dut (
      .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc),
      .if_instr(if_instr), .flush(flush), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
      .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
      .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
      .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
      .ex_funct7_5(ex_funct7_5), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
      .ex_branch(ex_branch), .ex_illegal(ex_illegal)
   );

   // {valid, alu_op[1:0], alu_src, reg_write, mem_read, mem_write, mem_to_reg, branch, illegal}
   logic [9:0] ctrl;
   assign ctrl = {ex_valid, ex_alu_op, ex_alu_src, ex_reg_write, ex_mem_read,
                  ex_mem_write, ex_mem_to_reg, ex_branch, ex_illegal};

   localparam logic [9:0] C_NONE = 10'b0_00_0_0_0_0_0_0_0;
   localparam logic [9:0] C_R    = 10'b1_10_0_1_0_0_0_0_0;
   localparam logic [9:0] C_IMM  = 10'b1_11_1_1_0_0_0_0_0;
   localparam logic [9:0] C_LD   = 10'b1_00_1_1_1_0_1_0_0;
   localparam logic [9:0] C_ST   = 10'b1_00_1_0_0_1_0_0_0;
   localparam logic [9:0] C_BR   = 10'b1_01_0_0_0_0_0_1_0;
   localparam logic [9:0] C_ILL  = 10'b1_00_0_0_0_0_0_0_1;

   localparam logic [31:0] I_ADD     = 32'h003082B3; // add  x5,x1,x3
   localparam logic [31:0] I_ADDI    = 32'hFFC08313; // addi x6,x1,-4
   localparam logic [31:0] I_SW      = 32'hFE20AC23; // sw   x2,-8(x1)
   localparam logic [31:0] I_BEQ     = 32'hFE2088E3; // beq  x1,x2,-16
   localparam logic [31:0] I_LD7     = 32'h0000B383; // ld   x7,0(x1)
   localparam logic [31:0] I_ADD_H   = 32'h00238433; // add  x8,x7,x2
   localparam logic [31:0] I_ADD_N   = 32'h00310433; // add  x8,x2,x3
   localparam logic [31:0] I_SW7     = 32'h00712023; // sw   x7,0(x2)
   localparam logic [31:0] I_ADDI7   = 32'h00708493; // addi x9,x1,7
   localparam logic [31:0] I_LD0     = 32'h0000B003; // ld   x0,0(x1)
   localparam logic [31:0] I_ADD00   = 32'h00000433; // add  x8,x0,x0

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [63:0] pc, input logic [31:0] instr);
      if_valid = 1'b1;
      if_pc    = pc;
      if_instr = instr;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 64'h1000 + 64'(i);
      rf[0] = '0;
      rf[1] = 64'd5;
      rf[3] = 64'd3;
      reset = 1'b1; if_valid = 1'b0; if_pc = '0; if_instr = '0; flush = 1'b0;
      #12;
      chk("reset_ctrl", 64'(ctrl), 64'(C_NONE));
      chk("reset_stall", 64'(stall), 64'd0);
      reset = 1'b0;

      issue(64'h100, I_ADD);
      cyc();
      chk("add_ctrl", 64'(ctrl), 64'(C_R));
      chk("add_rs1_data", ex_rs1_data, 64'd5);
      chk("add_rs2_data", ex_rs2_data, 64'd3);
      chk("add_rd", 64'(ex_rd), 64'd5);
      chk("add_imm", ex_imm, 64'd0);
      chk("add_pc", ex_pc, 64'h100);

      issue(64'h104, I_ADDI);
      chk("addi_nostall", 64'(stall), 64'd0);
      cyc();
      chk("addi_ctrl", 64'(ctrl), 64'(C_IMM));
      chk("addi_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("addi_rd", 64'(ex_rd), 64'd6);

      issue(64'h108, I_SW);
      cyc();
      chk("sw_ctrl", 64'(ctrl), 64'(C_ST));
      chk("sw_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFF8);
      chk("sw_funct3", 64'(ex_funct3), 64'd2);
      chk("sw_rs2_data", ex_rs2_data, 64'h1002);

      issue(64'h10C, I_BEQ);
      cyc();
      chk("beq_ctrl", 64'(ctrl), 64'(C_BR));
      chk("beq_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFF0);

      // load-use on rs1: one stall cycle, one bubble, then the add issues
      issue(64'h110, I_LD7);
      cyc();
      chk("ld_ctrl", 64'(ctrl), 64'(C_LD));
      chk("ld_rd", 64'(ex_rd), 64'd7);
      issue(64'h114, I_ADD_H);
      #1;
      chk("lu_stall", 64'(stall), 64'd1);
      cyc();
      chk("lu_bubble", 64'(ctrl), 64'(C_NONE));
      chk("lu_stall_drop", 64'(stall), 64'd0);
      cyc();
      chk("lu_issue_ctrl", 64'(ctrl), 64'(C_R));
      chk("lu_issue_rs1", 64'(ex_rs1), 64'd7);
      chk("lu_issue_pc", ex_pc, 64'h114);

      issue(64'h118, I_LD7);
      cyc();
      issue(64'h11C, I_ADD_N);
      #1;
      chk("noh_stall", 64'(stall), 64'd0);
      cyc();
      chk("noh_ctrl", 64'(ctrl), 64'(C_R));

      // hazard through rs2 of a store
      issue(64'h120, I_LD7);
      cyc();
      issue(64'h124, I_SW7);
      #1;
      chk("st_rs2_stall", 64'(stall), 64'd1);
      cyc();
      chk("st_rs2_bubble", 64'(ctrl), 64'(C_NONE));
      cyc();
      chk("st_rs2_issue", 64'(ctrl), 64'(C_ST));

      // addi's rs2 field equals x7 but it is not a register source
      issue(64'h128, I_LD7);
      cyc();
      issue(64'h12C, I_ADDI7);
      #1;
      chk("addi_rs2field_stall", 64'(stall), 64'd0);
      cyc();

      issue(64'h130, I_LD0);
      cyc();
      issue(64'h134, I_ADD00);
      #1;
      chk("ld_x0_stall", 64'(stall), 64'd0);
      cyc();

      // flush beats a pending load-use stall
      issue(64'h138, I_LD7);
      cyc();
      issue(64'h13C, I_ADD_H);
      #1;
      chk("fl_pre_stall", 64'(stall), 64'd1);
      flush = 1'b1;
      #1;
      chk("fl_stall", 64'(stall), 64'd0);
      cyc();
      chk("fl_bubble", 64'(ctrl), 64'(C_NONE));
      flush = 1'b0;

      issue(64'h140, I_ADDI);
      flush = 1'b1;
      cyc();
      chk("fl_normal", 64'(ctrl), 64'(C_NONE));
      flush = 1'b0;

      if_valid = 1'b0;
      cyc();
      chk("invalid_bubble", 64'(ctrl), 64'(C_NONE));

      issue(64'h144, 32'h0000007F);
      cyc();
      chk("illegal_ctrl", 64'(ctrl), 64'(C_ILL));

      // asynchronous reset in the middle of a stall
      issue(64'h148, I_LD7);
      cyc();
      issue(64'h14C, I_ADD_H);
      #1;
      chk("rst_pre_stall", 64'(stall), 64'd1);
      #1;
      reset = 1'b1;
      #1;
      chk("rst_async_ctrl", 64'(ctrl), 64'(C_NONE));
      chk("rst_async_stall", 64'(stall), 64'd0);
      chk("rst_async_pc", ex_pc, 64'd0);
      chk("rst_async_rd", 64'(ex_rd), 64'd0);
      reset = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
